sc_mux_adder_acc: RTL and testbench



---
 rtl/sc_pkg.sv | 17 +
 rtl/sc_lfsr16.sv | 39 +++
 rtl/sc_mux_adder_acc.sv | 135 +++++++++++++
 tb/tb_sc_mux_adder_acc.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/sc_pkg.sv
// sc_pkg: shared types and constants for the stochastic-computing blocks.
//   sc_frame_state_t     - frame controller states IDLE / RUN / DONE
//   LFSR16_TAPS          - feedback mask for the 16-bit Fibonacci LFSR
//                          (taps 16,14,13,11 -> bits 15,13,12,10)
//   SC_LFSR_SEED_DEFAULT - default nonzero LFSR seed
package sc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sc_frame_state_t;

    localparam logic [15:0] LFSR16_TAPS          = 16'hB400;
    localparam logic [15:0] SC_LFSR_SEED_DEFAULT = 16'hACE1;

endpackage

// File: rtl/sc_lfsr16.sv
// sc_lfsr16: 16-bit Fibonacci maximal-length LFSR, shifts left, feedback into bit 0.
// Ports:
//   clk, rst_n - clock, async active-low reset (register resets to RST_VAL)
//   load       - synchronous load of seed (wins over en)
//   en         - advance one step
//   seed       - value taken on load
//   q          - current LFSR state
module sc_lfsr16
    import sc_pkg::*;
#(
    parameter logic [15:0] RST_VAL = SC_LFSR_SEED_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        en,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic [15:0] lfsr_q, lfsr_d;
    logic        fb;

    assign fb = ^(lfsr_q & LFSR16_TAPS);

    always_comb begin
        lfsr_d = lfsr_q;
        if (load)    lfsr_d = seed;
        else if (en) lfsr_d = {lfsr_q[14:0], fb};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_q <= RST_VAL;
        else        lfsr_q <= lfsr_d;
    end

    assign q = lfsr_q;

endmodule

// File: rtl/sc_mux_adder_acc.sv
// sc_mux_adder_acc: N-input stochastic scaled adder with frame accumulator.
// Each RUN cycle one input bitstream is picked by a pseudo-random select, so the
// output stream encodes mean(p_i). One frame of STREAM_LEN samples runs per start;
// the ones count of the frame is returned on result with a one-cycle done pulse.
// Ports:
//   clk, rst_n - clock, async active-low reset
//   start      - frame request, honoured in IDLE or DONE only
//   x          - one stochastic bit per input channel
//   sel_ext    - external select (only when SC_ADDER_EXT_SEL_EN is defined)
//   out        - registered output stream bit, out_valid marks frame samples
//   busy       - state == RUN
//   done       - state == DONE (one cycle), result valid
//   result     - ones count of the last completed frame
// Build option: define SC_ADDER_EXT_SEL_EN to replace the internal LFSR select
// with the sel_ext port (LFSR is then not instantiated).
module sc_mux_adder_acc
    import sc_pkg::*;
#(
    parameter int          NUM_INPUTS = 4,
    parameter int          SEL_W      = $clog2(NUM_INPUTS),
    parameter int          STREAM_LEN = 256,
    parameter int          CNT_W      = $clog2(STREAM_LEN + 1),
    parameter logic [15:0] LFSR_SEED  = SC_LFSR_SEED_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [NUM_INPUTS-1:0] x,
`ifdef SC_ADDER_EXT_SEL_EN
    input  logic [SEL_W-1:0]      sel_ext,
`endif
    output logic                  out,
    output logic                  out_valid,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      result
);

    if (LFSR_SEED == 16'h0000) begin : g_bad_seed
        $error("sc_mux_adder_acc: LFSR_SEED must be nonzero");
    end

    sc_frame_state_t  state_q, state_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] ones_q, ones_d;
    logic [CNT_W-1:0] res_q, res_d;
    logic             out_q, out_d;
    logic             ov_q, ov_d;
    logic [SEL_W-1:0] sel;
    logic             samp;
    logic             last;

`ifdef SC_ADDER_EXT_SEL_EN
    assign sel = sel_ext;
`else
    logic [15:0] lfsr;
    logic        lfsr_load;

    // Reseed on every accepted start so identical x gives identical frames.
    assign lfsr_load = start && (state_q != RUN);

    sc_lfsr16 #(
        .RST_VAL (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (lfsr_load),
        .en    (state_q == RUN),
        .seed  (LFSR_SEED),
        .q     (lfsr)
    );

    assign sel = lfsr[SEL_W-1:0];
`endif

    assign samp = x[sel];
    assign last = (cyc_q == CNT_W'(STREAM_LEN - 1));

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        ones_d  = ones_q;
        res_d   = res_q;
        out_d   = out_q;
        ov_d    = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    cyc_d   = '0;
                    ones_d  = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                out_d  = samp;
                ov_d   = 1'b1;
                ones_d = ones_q + CNT_W'(samp);
                cyc_d  = cyc_q + CNT_W'(1);
                if (last) begin
                    state_d = DONE;
                    // Include the final sample, which lands in ones_q only at this edge.
                    res_d   = ones_q + CNT_W'(samp);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            ones_q  <= '0;
            res_q   <= '0;
            out_q   <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            ones_q  <= ones_d;
            res_q   <= res_d;
            out_q   <= out_d;
            ov_q    <= ov_d;
        end
    end

    assign out       = out_q;
    assign out_valid = ov_q;
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign result    = res_q;

endmodule

// File: tb/tb_sc_mux_adder_acc.sv
// Directed bench for sc_mux_adder_acc (NUM_INPUTS=4, STREAM_LEN=256).
// Expected streams come from an independent LFSR model seeded with 16'hACE1.
module tb_sc_mux_adder_acc;

    localparam int NI = 4;
    localparam int SL = 256;
    localparam int CW = 9;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [NI-1:0] x;
    logic          out, out_valid, busy, done;
    logic [CW-1:0] result;
`ifdef SC_ADDER_EXT_SEL_EN
    logic [1:0]    sel_ext = 2'd0;
`endif

    int checks = 0;
    int errors = 0;
    logic [CW-1:0] res_a;

    sc_mux_adder_acc dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .x         (x),
`ifdef SC_ADDER_EXT_SEL_EN
        .sel_ext   (sel_ext),
`endif
        .out       (out),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] m);
        return {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
    endfunction

    // Called at a negedge with the DUT in IDLE or DONE. pulse_at re-asserts start
    // before that sample edge (0 = never). With b2b the task returns in the DONE
    // cycle so the next call's start lands in DONE.
    task automatic run_frame(input logic [NI-1:0] xv, input int pulse_at, input bit b2b,
                             input string t);
        logic [15:0] m;
        logic [1:0]  s;
        logic        eo;
        int ones = 0, vcnt = 0, bcnt = 0, dcnt = 0, omis = 0;
        m = 16'hACE1;
        x = xv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({t, "_busy_rise"}, 32'(busy), 1);
        chk({t, "_ov_first"}, 32'(out_valid), 0);
        for (int i = 1; i <= SL; i++) begin
            start = (i == pulse_at);
`ifdef SC_ADDER_EXT_SEL_EN
            s = sel_ext;
`else
            s = m[1:0];
`endif
            eo = xv[s];
            ones += int'(eo);
            m = lfsr_step(m);
            @(negedge clk);
            if (out_valid) vcnt++;
            if (out !== eo) omis++;
            if (busy) bcnt++;
            if (done) dcnt++;
        end
        start = 1'b0;
        chk({t, "_out_stream_mis"}, omis, 0);
        chk({t, "_valid_cycles"}, vcnt, SL);
        chk({t, "_busy_cycles"}, bcnt, SL - 1);
        chk({t, "_done_in_frame"}, dcnt, 1);
        chk({t, "_done"}, 32'(done), 1);
        chk({t, "_result"}, 32'(result), ones);
        res_a = result;
        if (!b2b) begin
            @(negedge clk);
            chk({t, "_done_one_cycle"}, 32'(done), 0);
            chk({t, "_ov_after"}, 32'(out_valid), 0);
            chk({t, "_result_held"}, 32'(result), 32'(res_a));
        end
    endtask

    initial begin
        logic [CW-1:0] r1;
        int dcnt, bcnt, mis;
        rst_n = 1'b0;
        start = 1'b0;
        x     = '0;
        #3;
        chk("rst_out", 32'(out), 0);
        chk("rst_ov", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_result", 32'(result), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 0);

        run_frame(4'b0000, 0, 1'b0, "x0000");
        chk("x0000_const", 32'(res_a), 0);
        run_frame(4'b1111, 0, 1'b0, "x1111");
        chk("x1111_const", 32'(res_a), SL);
        run_frame(4'b0001, 0, 1'b0, "x0001");

        // Mid-RUN start is ignored; start in DONE chains a reseeded frame.
        run_frame(4'b0110, 50, 1'b1, "restart");
        r1 = res_a;
        run_frame(4'b0110, 0, 1'b0, "b2b");
        chk("b2b_same_result", 32'(res_a), 32'(r1));

        // Reset at sample 100 of a frame; prior result (nonzero) must be lost.
        x = 4'b1111;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out", 32'(out), 0);
        chk("midrst_ov", 32'(out_valid), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_result", 32'(result), 0);
        @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        bcnt = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done) dcnt++;
            if (busy) bcnt++;
        end
        chk("midrst_no_done", dcnt, 0);
        chk("midrst_idle", bcnt, 0);

`ifdef SC_ADDER_EXT_SEL_EN
        // External select on channel 2 with x[2] toggling 1,0,1,0...
        sel_ext = 2'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mis = 0;
        for (int i = 1; i <= SL; i++) begin
            x = (i % 2 == 1) ? 4'b0100 : 4'b1011;
            @(negedge clk);
            if (out !== x[2] || !out_valid) mis++;
        end
        chk("ext_stream_mis", mis, 0);
        chk("ext_done", 32'(done), 1);
        chk("ext_result", 32'(result), 128);
`else
        mis = 0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule
